// File: rtl/imm_ext_if.sv
// Handshake bundle for imm_ext_pipe: request side (Imm/ExtMode) and result side (DataExt).
// The producer/consumer environment uses the master modport, and the pipe uses the slave modport.
interface imm_ext_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic [IN_W-1:0]  Imm;
  logic [1:0]       ExtMode;
  logic             InValid;
  logic             InReady;
  logic [OUT_W-1:0] DataExt;
  logic             OutValid;
  logic             OutReady;
  logic [15:0]      XferCnt;

  modport master (
    output Imm, ExtMode, InValid, OutReady,
    input  InReady, DataExt, OutValid, XferCnt
  );

  modport slave (
    input  Imm, ExtMode, InValid, OutReady,
    output InReady, DataExt, OutValid, XferCnt
  );
endinterface

// File: rtl/imm_ext_pipe.sv
// Immediate extender with a 2-entry result FIFO (1-cycle latency, ready/valid on both sides).
// Optional output-transfer counter enabled by macro IMM_EXT_XFER_CNT_EN.
module imm_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic       CLK,
  input  logic       RST_n,
  imm_ext_if.slave   bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occState_t;

  occState_t        state, stateNext;
  logic [OUT_W-1:0] mem [2];
  logic             wrPtr, rdPtr;
  logic             push, pop;
  logic             inReady, outValid;
  logic [OUT_W-1:0] extVal;
  logic [OUT_W-1:0] sext;

  always_comb begin
    sext   = {{(OUT_W-IN_W){bus.Imm[IN_W-1]}}, bus.Imm};
    extVal = '0;
    case (bus.ExtMode)
      2'b00:   extVal = {{(OUT_W-IN_W){1'b0}}, bus.Imm};
      2'b01:   extVal = sext;
      2'b10:   extVal = {bus.Imm, {(OUT_W-IN_W){1'b0}}};
      default: extVal = {sext[OUT_W-3:0], 2'b00};
    endcase
  end

  // Ready depends only on registered state, so a pop in FULL cannot admit a same-cycle push.
  always_comb begin
    stateNext = state;
    inReady   = 1'b0;
    outValid  = 1'b0;
    case (state)
      EMPTY: inReady = 1'b1;
      ONE: begin
        inReady  = 1'b1;
        outValid = 1'b1;
      end
      FULL:    outValid = 1'b1;
      default: ;
    endcase

    push = bus.InValid & inReady;
    pop  = outValid & bus.OutReady;

    case ({push, pop})
      2'b10: begin
        case (state)
          EMPTY:   stateNext = ONE;
          ONE:     stateNext = FULL;
          default: stateNext = state;
        endcase
      end
      2'b01: begin
        case (state)
          FULL:    stateNext = ONE;
          ONE:     stateNext = EMPTY;
          default: stateNext = state;
        endcase
      end
      default: stateNext = state;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state <= EMPTY;
      wrPtr <= 1'b0;
      rdPtr <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state <= stateNext;
      if (push) begin
        mem[wrPtr] <= extVal;
        wrPtr      <= ~wrPtr;
      end
      if (pop) begin
        rdPtr <= ~rdPtr;
      end
    end
  end

  assign bus.InReady  = inReady;
  assign bus.OutValid = outValid;
  assign bus.DataExt  = (state == EMPTY) ? '0 : mem[rdPtr];

`ifdef IMM_EXT_XFER_CNT_EN
  logic [15:0] xferCnt;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      xferCnt <= '0;
    end else if (pop && (xferCnt != 16'hFFFF)) begin
      xferCnt <= xferCnt + 16'd1;
    end
  end

  assign bus.XferCnt = xferCnt;
`else
  assign bus.XferCnt = '0;
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: vector table, corner-case sequences and random traffic
// compared against a queue-based reference model.
module tb_imm_ext_pipe;

  logic CLK;
  logic RST_n;

  imm_ext_if #(.IN_W(16), .OUT_W(32)) b ();
  imm_ext_if #(.IN_W(12), .OUT_W(32)) b2 ();

  imm_ext_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (b)
  );

  imm_ext_pipe #(.IN_W(12), .OUT_W(32)) dut12 (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (b2)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int errors = 0;

  logic [31:0] q[$];
  int unsigned xfers = 0;

  typedef struct {
    logic [15:0] imm;
    logic [1:0]  mode;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[6];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Extension rules from arithmetic: signed value of an IN_W-bit field, times 2^k, mod 2^32.
  function automatic logic [31:0] refExt(int unsigned imm, int unsigned mode, int w);
    longint v;
    longint s;
    logic [63:0] r;
    s = longint'(imm);
    if (imm >= (32'd1 << (w - 1))) s = s - (longint'(1) << w);
    case (mode)
      0:       v = longint'(imm);
      1:       v = s;
      2:       v = longint'(imm) * (longint'(1) << (32 - w));
      default: v = s * 4;
    endcase
    r = v;
    return r[31:0];
  endfunction

  function automatic logic [15:0] expCnt();
`ifdef IMM_EXT_XFER_CNT_EN
    return (xfers > 65535) ? 16'hFFFF : 16'(xfers);
`else
    return 16'h0000;
`endif
  endfunction

  function automatic void checkOuts();
    chk("InReady",  64'(b.InReady),  64'(q.size() < 2));
    chk("OutValid", 64'(b.OutValid), 64'(q.size() > 0));
    chk("DataExt",  64'(b.DataExt),  64'((q.size() > 0) ? q[0] : 32'h0));
    chk("XferCnt",  64'(b.XferCnt),  64'(expCnt()));
  endfunction

  task automatic cycle(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                       input logic ordy);
    logic doPush;
    logic doPop;
    checkOuts();
    b.InValid  = v;
    b.Imm      = imm;
    b.ExtMode  = mode;
    b.OutReady = ordy;
    doPush = v && (q.size() < 2);
    doPop  = (q.size() > 0) && ordy;
    @(posedge CLK);
    #1;
    if (doPop) begin
      void'(q.pop_front());
      xfers++;
    end
    if (doPush) q.push_back(refExt(imm, mode, 16));
  endtask

  initial begin
    tbl[0] = '{16'h8001, 2'b00, 32'h00008001};
    tbl[1] = '{16'h8001, 2'b01, 32'hFFFF8001};
    tbl[2] = '{16'h8001, 2'b10, 32'h80010000};
    tbl[3] = '{16'h8001, 2'b11, 32'hFFFE0004};
    tbl[4] = '{16'h7FFF, 2'b01, 32'h00007FFF};
    tbl[5] = '{16'h7FFF, 2'b11, 32'h0001FFFC};

    RST_n      = 1'b0;
    b.InValid  = 1'b0;
    b.Imm      = '0;
    b.ExtMode  = '0;
    b.OutReady = 1'b0;
    b2.InValid  = 1'b0;
    b2.Imm      = '0;
    b2.ExtMode  = '0;
    b2.OutReady = 1'b1;

    #3;
    chk("rst_OutValid", 64'(b.OutValid), 64'(0));
    chk("rst_InReady",  64'(b.InReady),  64'(1));
    chk("rst_DataExt",  64'(b.DataExt),  64'(0));
    chk("rst_XferCnt",  64'(b.XferCnt),  64'(0));
    #9 RST_n = 1'b1;
    @(posedge CLK);
    #1;

    // Mode table: each result visible one edge after acceptance.
    foreach (tbl[i]) begin
      cycle(1'b1, tbl[i].imm, tbl[i].mode, 1'b1);
      chk($sformatf("tbl%0d_DataExt", i), 64'(b.DataExt), 64'(tbl[i].exp));
      chk($sformatf("tbl%0d_OutValid", i), 64'(b.OutValid), 64'(1));
    end
    cycle(1'b0, 16'h0, 2'b00, 1'b1);

    // Backpressure: fill, ignored third request, then drain in order.
    cycle(1'b1, 16'h0001, 2'b00, 1'b0);
    cycle(1'b1, 16'h0002, 2'b00, 1'b0);
    chk("bp_InReady_full", 64'(b.InReady), 64'(0));
    cycle(1'b1, 16'h0003, 2'b00, 1'b0);
    chk("bp_hold_DataExt", 64'(b.DataExt), 64'(32'h1));
    cycle(1'b0, 16'h0, 2'b00, 1'b1);
    chk("bp_first_pop_InReady", 64'(b.InReady), 64'(1));
    chk("bp_second_DataExt", 64'(b.DataExt), 64'(32'h2));
    cycle(1'b0, 16'h0, 2'b00, 1'b1);
    chk("bp_drained_OutValid", 64'(b.OutValid), 64'(0));

    // Full + pop + push request: push must be refused this cycle.
    cycle(1'b1, 16'h0010, 2'b01, 1'b0);
    cycle(1'b1, 16'h0011, 2'b01, 1'b0);
    cycle(1'b1, 16'h0012, 2'b01, 1'b1);
    chk("full_pop_no_push_DataExt", 64'(b.DataExt), 64'(32'h11));
    cycle(1'b0, 16'h0, 2'b00, 1'b1);
    chk("full_pop_no_push_empty", 64'(b.OutValid), 64'(0));

    // Streaming: state stays ONE, one result per cycle.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 16'(i), 2'b01, 1'b1);
      chk("stream_DataExt", 64'(b.DataExt), 64'(i));
      chk("stream_InReady", 64'(b.InReady), 64'(1));
    end
    cycle(1'b0, 16'h0, 2'b00, 1'b1);

    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom), 16'($urandom), 2'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    // Reset between edges while FULL.
    cycle(1'b1, 16'hAAAA, 2'b10, 1'b0);
    cycle(1'b1, 16'h5555, 2'b10, 1'b0);
    b.InValid = 1'b0;
    chk("pre_rst_full", 64'(b.InReady), 64'(0));
    #2 RST_n = 1'b0;
    #1;
    chk("midrst_OutValid", 64'(b.OutValid), 64'(0));
    chk("midrst_InReady",  64'(b.InReady),  64'(1));
    chk("midrst_DataExt",  64'(b.DataExt),  64'(0));
    chk("midrst_XferCnt",  64'(b.XferCnt),  64'(0));
    q.delete();
    xfers = 0;
    #1 RST_n = 1'b1;
    @(posedge CLK);
    #1;
    checkOuts();

    // Narrow-immediate instance.
    b2.InValid = 1'b1;
    b2.Imm     = 12'h800;
    b2.ExtMode = 2'b11;
    @(posedge CLK);
    #1;
    b2.ExtMode = 2'b10;
    chk("w12_mode11", 64'(b2.DataExt), 64'(32'hFFFFE000));
    @(posedge CLK);
    #1;
    b2.InValid = 1'b0;
    chk("w12_mode10", 64'(b2.DataExt), 64'(32'h80000000));

    // Counter saturation: 65537 output transfers.
    for (int i = 0; i < 65538; i++) begin
      cycle(1'b1, 16'(i), 2'b00, 1'b1);
    end
    chk("xfers_done", 64'(xfers), 64'(65537));
`ifdef IMM_EXT_XFER_CNT_EN
    chk("cnt_saturated", 64'(b.XferCnt), 64'(16'hFFFF));
`else
    chk("cnt_disabled", 64'(b.XferCnt), 64'(0));
`endif
    cycle(1'b0, 16'h0, 2'b00, 1'b1);
    checkOuts();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
